// File: rtl/cosim_cycle_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cosim_cycle_pkg : shared types, endpoint IDs and response packing helper
// Rev 1.0
// ---------------------------------------------------------------------------
package cosim_cycle_pkg;

  localparam int unsigned RESP_BITS  = 128;
  localparam int unsigned FIELD_BITS = 64;

  localparam string ARG_ENDPOINT_ID    = "__cosim_cycle_count.arg";
  localparam string RESULT_ENDPOINT_ID = "__cosim_cycle_count.result";
  localparam string RESULT_TYPE_ID     = "struct{cycle:int<64>,freq:int<64>}";

  // First member lands in the upper half of the packed 128-bit word.
  typedef struct packed {
    longint unsigned cycle;
    longint unsigned freq;
  } cycle_resp_t;

  function automatic cycle_resp_t make_resp(input logic [FIELD_BITS-1:0] cycle,
                                            input logic [FIELD_BITS-1:0] freq);
    cycle_resp_t r;
    r.cycle = cycle;
    r.freq  = freq;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cosim_stamp_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cosim_stamp_fifo : valid/ready FIFO with wrap-bit pointers and occupancy
// Rev 1.0
// ---------------------------------------------------------------------------
module cosim_stamp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_valid_i,
  output logic                     push_ready_o,
  input  logic [WIDTH-1:0]         push_data_i,
  output logic                     pop_valid_o,
  input  logic                     pop_ready_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic [$clog2(DEPTH):0]   occupancy_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             push_ready_q;
  logic             empty;
  logic             full_d;
  logic             push;
  logic             pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = push_valid_i && push_ready_q;
  assign pop   = !empty && pop_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  assign full_d = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);

  // Ready is computed from next-state pointers so it is a pure flop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      push_ready_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      push_ready_q <= !full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  assign push_ready_o = push_ready_q;
  assign pop_valid_o  = !empty;
  assign pop_data_o   = mem_q[rd_ptr_q[AW-1:0]];
  assign occupancy_o  = wr_ptr_q - rd_ptr_q;

endmodule
`default_nettype wire

// File: rtl/cosim_cycle_stamp_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cosim_cycle_stamp_queue : stamps accepted cycle-count requests, queues them
// Rev 1.0
// ---------------------------------------------------------------------------
module cosim_cycle_stamp_queue
  import cosim_cycle_pkg::*;
#(
  parameter int unsigned DEPTH                   = 4,
  parameter logic [63:0] CORE_CLOCK_FREQUENCY_HZ = 64'd0,
  parameter int unsigned COUNT_WIDTH             = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   count_en,
  input  logic                   req_valid,
  output logic                   req_ready,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [RESP_BITS-1:0]   resp_data,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [15:0]            drop_count
);

  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  logic [COUNT_WIDTH-1:0] cycle_count_q, cycle_count_d;
  logic [15:0]            drop_count_q, drop_count_d;
  logic [COUNT_WIDTH-1:0] head_cycle;
  logic                   fifo_full;
  cycle_resp_t            resp;

  always_comb begin
    cycle_count_d = cycle_count_q;
    if (count_en) cycle_count_d = cycle_count_q + COUNT_WIDTH'(1);
  end

  assign fifo_full = (occupancy == OCC_W'(DEPTH));

  always_comb begin
    drop_count_d = drop_count_q;
    if (req_valid && fifo_full && (drop_count_q != 16'hFFFF))
      drop_count_d = drop_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      cycle_count_q <= cycle_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  // The stamp is the pre-increment count of the accepting cycle.
  cosim_stamp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (COUNT_WIDTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_valid_i (req_valid),
    .push_ready_o (req_ready),
    .push_data_i  (cycle_count_q),
    .pop_valid_o  (resp_valid),
    .pop_ready_i  (resp_ready),
    .pop_data_o   (head_cycle),
    .occupancy_o  (occupancy)
  );

  assign resp       = make_resp(FIELD_BITS'(head_cycle), CORE_CLOCK_FREQUENCY_HZ);
  assign resp_data  = resp;
  assign drop_count = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_cosim_cycle_stamp_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cosim_cycle_stamp_queue : directed self-checking bench for the stamp queue
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_cosim_cycle_stamp_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [63:0] FREQ  = 64'd250_000_000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         count_en = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [127:0] resp_data;
  logic [2:0]   occupancy;
  logic [15:0]  drop_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  cosim_cycle_stamp_queue #(
    .DEPTH                   (DEPTH),
    .CORE_CLOCK_FREQUENCY_HZ (FREQ),
    .COUNT_WIDTH             (64)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_en   (count_en),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .occupancy  (occupancy),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic req_at(input int n);
    run_to(n);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Holds reset for two edges, then releases so the current cycle is cycle 0.
  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    tick();
    tick();
    check_eq("rst_resp_valid", resp_valid, 1'b0);
    check_eq("rst_req_ready", req_ready, 1'b0);
    check_eq("rst_occupancy", occupancy, 3'd0);
    check_eq("rst_drop", drop_count, 16'd0);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic expect_head(input string tag, input logic [63:0] stamp);
    check_eq({tag, "_valid"}, resp_valid, 1'b1);
    check_eq({tag, "_data"}, resp_data, {stamp, FREQ});
  endtask

  initial begin
    // Single request with an always-ready response channel.
    resp_ready = 1'b1;
    do_reset();
    req_at(10);
    expect_head("t1", 64'd10);
    check_eq("t1_occ", occupancy, 3'd1);
    tick();
    check_eq("t1_occ_after", occupancy, 3'd0);
    check_eq("t1_valid_after", resp_valid, 1'b0);

    // Backpressure: four stamps queued, then drained in order.
    resp_ready = 1'b0;
    do_reset();
    req_at(5);
    req_at(6);
    req_at(9);
    req_at(20);
    check_eq("t2_req_ready", req_ready, 1'b0);
    check_eq("t2_occ", occupancy, 3'd4);
    expect_head("t2_hold0", 64'd5);
    tick();
    tick();
    expect_head("t2_hold2", 64'd5);
    resp_ready = 1'b1;
    tick();
    expect_head("t2_pop1", 64'd6);
    check_eq("t2_ready_back", req_ready, 1'b1);
    tick();
    expect_head("t2_pop2", 64'd9);
    tick();
    expect_head("t2_pop3", 64'd20);
    tick();
    check_eq("t2_empty", resp_valid, 1'b0);

    // Overflow: requests held against a full queue are counted, not pushed.
    resp_ready = 1'b0;
    do_reset();
    req_at(2);
    req_at(3);
    req_at(4);
    req_at(5);
    check_eq("t3_full_ready", req_ready, 1'b0);
    req_valid = 1'b1;
    tick();
    tick();
    tick();
    req_valid = 1'b0;
    check_eq("t3_drop", drop_count, 16'd3);
    check_eq("t3_occ_full", occupancy, 3'd4);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check_eq("t3_occ_freed", occupancy, 3'd3);
    check_eq("t3_ready_freed", req_ready, 1'b1);
    req_at(10);
    check_eq("t3_occ_refill", occupancy, 3'd4);
    check_eq("t3_drop_hold", drop_count, 16'd3);
    resp_ready = 1'b1;
    expect_head("t3_d0", 64'd3);
    tick();
    expect_head("t3_d1", 64'd4);
    tick();
    expect_head("t3_d2", 64'd5);
    tick();
    expect_head("t3_d3", 64'd10);
    tick();
    check_eq("t3_empty", resp_valid, 1'b0);

    // Counter holds while count_en is low for cycles 10..19.
    resp_ready = 1'b1;
    do_reset();
    run_to(10);
    count_en = 1'b0;
    run_to(20);
    count_en = 1'b1;
    req_at(25);
    expect_head("t4", 64'd15);

    // Wrap of the 64-bit counter.
    resp_ready = 1'b0;
    do_reset();
    run_to(3);
    count_en = 1'b0;
    force dut.cycle_count_q = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    release dut.cycle_count_q;
    count_en  = 1'b1;
    req_valid = 1'b1;
    tick();
    tick();
    tick();
    req_valid = 1'b0;
    check_eq("t5_occ", occupancy, 3'd3);
    resp_ready = 1'b1;
    expect_head("t5_s0", 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    expect_head("t5_s1", 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    expect_head("t5_s2", 64'd0);
    tick();
    check_eq("t5_empty", resp_valid, 1'b0);

    // Reset mid-cycle with stamps queued.
    resp_ready = 1'b0;
    do_reset();
    req_at(2);
    req_at(3);
    req_at(4);
    check_eq("t6_occ_pre", occupancy, 3'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_async_valid", resp_valid, 1'b0);
    check_eq("t6_async_occ", occupancy, 3'd0);
    check_eq("t6_async_ready", req_ready, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    cyc   = 0;
    resp_ready = 1'b1;
    tick();
    check_eq("t6_no_stale", resp_valid, 1'b0);
    req_at(7);
    expect_head("t6_post", 64'd7);
    tick();
    check_eq("t6_empty", resp_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
